alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one ALU_2 instance between two requesters: req0 (execute stage) and req1 (address/branch helper).
- Each request is a one-shot operation (operand A, operand B, 3-bit opcode) transferred with a valid/ready handshake.
- The block arbitrates round-robin, drives the ALU with registered operands, captures the result and zero flag, and returns them to the owning requester through a response handshake.
- It sits between the control path and the ALU; the ALU itself stays purely combinational.

Parameters:
- N, 16, datapath width (operands, result).
- OPW, 3, ALU control width.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle when valid is also high.
- req0_a  input  N  requester 0 operand A.
- req0_b  input  N  requester 0 operand B.
- req0_op  input  OPW  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as req0 for requester 1.
- resp0_valid  output  1  result available for requester 0.
- resp0_ready  input  1  requester 0 consumes result.
- resp1_valid  output  1  result available for requester 1.
- resp1_ready  input  1  requester 1 consumes result.
- resp_data  output  N  result, shared by both responses.
- resp_zero  output  1  zero flag of the result, shared.
- alu_in_1  output  N  to ALU_in_1.
- alu_in_2  output  N  to ALU_in_2.
- alu_ctrl  output  OPW  to ALU_control_out.
- alu_out  input  N  from ALU_out.
- alu_zero  input  1  from Zero_flag.
- ops_done  output  CNTW  count of completed responses, wraps modulo 2^CNTW.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst_n=0):
  - State=IDLE, rr_ptr=0, owner=0.
  - alu_in_1, alu_in_2, alu_ctrl, resp_data, resp_zero, ops_done all 0.
  - All ready and valid outputs 0.
- IDLE:
  - reqN_ready is combinational: only the grant winner sees ready=1.
  - Winner rule: if only one reqN_valid is high, that requester wins. If both are high, the winner is rr_ptr. If neither is high, no ready is driven and the state stays IDLE.
  - On valid&ready: latch a/b/op into alu_in_1/alu_in_2/alu_ctrl, record owner, go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU settles on the registered operands.
  - At the clock edge: resp_data<=alu_out, resp_zero<=alu_zero, rr_ptr<=~owner, go to RESP.
- RESP:
  - resp{owner}_valid=1; the other resp valid stays 0.
  - resp_data and resp_zero are held stable.
  - Both reqN_ready are 0.
  - On resp{owner}_ready=1: ops_done increments and the state returns to IDLE.
  - resp_ready of the non-owner is ignored.
- Latency: accept at edge k; response valid from edge k+2. Minimum issue interval is 3 cycles.
- alu_in_*/alu_ctrl hold their last values outside EXEC (no toggling when idle).
- A requester may drop valid before it is accepted; nothing is recorded.
- After acceptance, the requester's inputs are don't-care.
- Requests are never lost. A losing requester keeps valid high and wins the next arbitration because rr_ptr has moved to it.
- Reset asserted mid-EXEC or mid-RESP aborts the operation immediately; no response is ever issued for it.
- ops_done wraps from 2^CNTW-1 to 0.

Test Plan:
- After reset, req0 a=20, b=10, op=0 (add) -> req0_ready=1 in the accept cycle; resp0_valid 2 cycles later with resp_data=30, resp_zero=0, resp1_valid=0; ops_done=1 after the handshake.
- req1 a=10, b=10, op=1 (sub) -> resp1_valid with resp_data=0, resp_zero=1.
- req0 and req1 valid together from reset, both held -> grant order req0, req1, req0, req1 (alternating); the results match each requester's operands.
- Hold resp0_ready=0 for 5 cycles -> resp0_valid and resp_data stay stable; req1_ready stays 0 throughout; the transaction completes when ready rises.
- Pulse rst_n low during EXEC -> all outputs are 0 asynchronously; state is IDLE; no resp_valid appears afterwards; ops_done=0.
- Preload ops_done to 0xFFFF (or run 65536 ops in a fast test) -> the next completion wraps ops_done to 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the arbiter.
// Handshakes: a transfer occurs on a rising clk edge where valid && ready are both high.
interface alu_arbiter_if #(
  parameter int N   = 16,
  parameter int OPW = 3
);
  logic           req0_valid;
  logic           req0_ready;
  logic [N-1:0]   req0_a;
  logic [N-1:0]   req0_b;
  logic [OPW-1:0] req0_op;
  logic           req1_valid;
  logic           req1_ready;
  logic [N-1:0]   req1_a;
  logic [N-1:0]   req1_b;
  logic [OPW-1:0] req1_op;
  logic           resp0_valid;
  logic           resp0_ready;
  logic           resp1_valid;
  logic           resp1_ready;
  logic [N-1:0]   resp_data;
  logic           resp_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_data, resp_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_data, resp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time: IDLE (arbitrate) -> EXEC (ALU settles) -> RESP (return result).
module alu_arbiter #(
  parameter int N    = 16,
  parameter int OPW  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    bus,
  output logic [N-1:0]    alu_in_1,
  output logic [N-1:0]    alu_in_2,
  output logic [OPW-1:0]  alu_ctrl,
  input  logic [N-1:0]    alu_out,
  input  logic            alu_zero,
  output logic [CNTW-1:0] ops_done,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            owner_q, owner_d;
  logic [N-1:0]    in1_q, in1_d;
  logic [N-1:0]    in2_q, in2_d;
  logic [OPW-1:0]  ctrl_q, ctrl_d;
  logic [N-1:0]    data_q, data_d;
  logic            zero_q, zero_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            grant0, grant1;
  logic            owner_resp_ready;

  // rr_ptr only matters when both requesters contend.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr_q);
  assign grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr_q);
  assign owner_resp_ready = owner_q ? bus.resp1_ready : bus.resp0_ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          in1_d   = bus.req0_a;
          in2_d   = bus.req0_b;
          ctrl_d  = bus.req0_op;
          owner_d = 1'b0;
          state_d = EXEC;
        end else if (grant1) begin
          in1_d   = bus.req1_a;
          in2_d   = bus.req1_b;
          ctrl_d  = bus.req1_op;
          owner_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d   = alu_out;
        zero_d   = alu_zero;
        rr_ptr_d = ~owner_q;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_resp_ready) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      ctrl_q   <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
    end
  end

  // Ready is qualified by rst_n so nothing is offered while reset is held.
  assign bus.req0_ready  = rst_n && (state_q == IDLE) && grant0;
  assign bus.req1_ready  = rst_n && (state_q == IDLE) && grant1;
  assign bus.resp0_valid = (state_q == RESP) && !owner_q;
  assign bus.resp1_valid = (state_q == RESP) &&  owner_q;
  assign bus.resp_data   = data_q;
  assign bus.resp_zero   = zero_q;
  assign alu_in_1        = in1_q;
  assign alu_in_2        = in2_q;
  assign alu_ctrl        = ctrl_q;
  assign ops_done        = cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small combinational ALU model attached.
// A 4-bit completion counter keeps the wrap-around case short.
module tb_alu_arbiter;
  localparam int N    = 16;
  localparam int OPW  = 3;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.N(N), .OPW(OPW)) bus ();

  logic [N-1:0]    alu_in_1, alu_in_2, alu_out;
  logic [OPW-1:0]  alu_ctrl;
  logic            alu_zero;
  logic [CNTW-1:0] ops_done;
  logic [1:0]      dbg_state;

  alu_arbiter #(.N(N), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .alu_in_1  (alu_in_1),
    .alu_in_2  (alu_in_2),
    .alu_ctrl  (alu_ctrl),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .ops_done  (ops_done),
    .dbg_state (dbg_state)
  );

  // ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor.
  always_comb begin
    case (alu_ctrl)
      3'd0:    alu_out = alu_in_1 + alu_in_2;
      3'd1:    alu_out = alu_in_1 - alu_in_2;
      3'd2:    alu_out = alu_in_1 & alu_in_2;
      3'd3:    alu_out = alu_in_1 | alu_in_2;
      3'd4:    alu_out = alu_in_1 ^ alu_in_2;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  int checks = 0;
  int errors = 0;
  logic [CNTW-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic [N-1:0] a, input logic [N-1:0] b, input logic [OPW-1:0] op);
    bus.req0_valid = 1'b1;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_op    = op;
  endtask

  task automatic drive1(input logic [N-1:0] a, input logic [N-1:0] b, input logic [OPW-1:0] op);
    bus.req1_valid = 1'b1;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_op    = op;
  endtask

  // One full transaction starting in IDLE: w is the expected winner.
  task automatic xact(input int w, input logic [N-1:0] ed, input logic ez,
                      input int hold, input bit drop);
    #1;
    chk("grant0", 32'(bus.req0_ready), 32'(w == 0));
    chk("grant1", 32'(bus.req1_ready), 32'(w == 1));
    @(posedge clk); #1;
    if (drop) begin
      if (w == 0) bus.req0_valid = 1'b0;
      else        bus.req1_valid = 1'b0;
    end
    @(negedge clk);
    chk("exec_state", 32'(dbg_state), 32'd1);
    chk("exec_no_resp", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
    @(posedge clk); #1;
    bus.resp0_ready = (w == 0) ? (hold == 0) : 1'b1;
    bus.resp1_ready = (w == 1) ? (hold == 0) : 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'({bus.resp1_valid, bus.resp0_valid}), (w == 0) ? 32'd1 : 32'd2);
      chk("hold_data", 32'(bus.resp_data), 32'(ed));
      chk("hold_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      chk("hold_cnt", 32'(ops_done), 32'(exp_cnt));
      @(posedge clk); #1;
    end
    if (w == 0) bus.resp0_ready = 1'b1;
    else        bus.resp1_ready = 1'b1;
    @(negedge clk);
    chk("resp_valid", 32'({bus.resp1_valid, bus.resp0_valid}), (w == 0) ? 32'd1 : 32'd2);
    chk("resp_data", 32'(bus.resp_data), 32'(ed));
    chk("resp_zero", 32'(bus.resp_zero), 32'(ez));
    @(posedge clk); #1;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    chk("done_state", 32'(dbg_state), 32'd0);
    chk("done_no_resp", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
    chk("ops_done", 32'(ops_done), 32'(exp_cnt));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.req0_valid  = 1'b1;
    bus.req0_a      = '0;
    bus.req0_b      = '0;
    bus.req0_op     = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_a      = '0;
    bus.req1_b      = '0;
    bus.req1_op     = '0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    exp_cnt         = '0;

    // Reset state, with a request pending that must not be offered ready.
    #12;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    chk("rst_valid", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
    chk("rst_alu", 32'({alu_in_1, alu_in_2}), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_data", 32'({bus.resp_zero, bus.resp_data}), 32'd0);
    chk("rst_cnt", 32'(ops_done), 32'd0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // req0 add 20+10
    drive0(16'd20, 16'd10, 3'd0);
    xact(0, 16'd30, 1'b0, 0, 1'b1);
    chk("alu_in_held", 32'({alu_in_1, alu_in_2}), {16'd20, 16'd10});

    // req1 sub 10-10 -> zero
    drive1(16'd10, 16'd10, 3'd1);
    xact(1, 16'd0, 1'b1, 0, 1'b1);

    // Contention with rr_ptr back at 0; req0 response stalled 5 cycles.
    drive0(16'h1234, 16'h0F0F, 3'd2);
    drive1(16'd5, 16'd3, 3'd4);
    xact(0, 16'h0204, 1'b0, 5, 1'b1);
    // The loser kept valid and wins now.
    xact(1, 16'd6, 1'b0, 0, 1'b1);

    // Add overflow wraps to zero.
    drive0(16'hFFFF, 16'd1, 3'd0);
    xact(0, 16'd0, 1'b1, 0, 1'b1);
    chk("cnt_five", 32'(ops_done), 32'd5);

    // Reset during EXEC aborts the operation.
    drive0(16'd9, 16'd4, 3'd3);
    #1;
    chk("abort_grant", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid  = 1'b0;
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    chk("abort_in_exec", 32'(dbg_state), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(dbg_state), 32'd0);
    chk("abort_alu", 32'({alu_in_1, alu_in_2}), 32'd0);
    chk("abort_ctrl", 32'(alu_ctrl), 32'd0);
    chk("abort_data", 32'({bus.resp_zero, bus.resp_data}), 32'd0);
    chk("abort_cnt", 32'(ops_done), 32'd0);
    chk("abort_valid", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
      chk("abort_idle", 32'(dbg_state), 32'd0);
    end
    bus.resp0_ready = 1'b0;

    // Both held from reset: grants alternate req0, req1, req0, req1.
    drive0(16'd100, 16'd1, 3'd0);
    drive1(16'd7, 16'd3, 3'd2);
    xact(0, 16'd101, 1'b0, 0, 1'b0);
    xact(1, 16'd3, 1'b0, 0, 1'b0);
    xact(0, 16'd101, 1'b0, 0, 1'b0);
    xact(1, 16'd3, 1'b0, 0, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("cnt_four", 32'(ops_done), 32'd4);

    // Twelve more completions take the 4-bit counter past 15 back to 0.
    for (int i = 0; i < 12; i++) begin
      drive0(16'(i), 16'd1, 3'd0);
      xact(0, 16'(i + 1), 1'b0, 0, 1'b1);
    end
    chk("cnt_wrap", 32'(ops_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
